// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// One access per 3 cycles minimum; the loser's request is held until the port returns to IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_done,
    output logic                if_err,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_done,
    output logic                d_err,

    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic              last_d;   // 1 when the data side won the previous grant
    logic              owner_d;  // 1 when the data side owns the current transaction
    logic [CNT_W-1:0]  wait_cnt;
    logic              pick_d;
    logic [DATA_W-1:0] resp_data;

    // On a tie the side not granted last wins.
    assign pick_d    = d_req && (!if_req || !last_d);
    assign resp_data = (mem_ready && !mem_we) ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            owner_d   <= 1'b0;
            wait_cnt  <= '0;
            if_gnt    <= 1'b0;
            if_rdata  <= '0;
            if_done   <= 1'b0;
            if_err    <= 1'b0;
            d_gnt     <= 1'b0;
            d_rdata   <= '0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_done <= 1'b0;
            if_err  <= 1'b0;
            d_done  <= 1'b0;
            d_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        state    <= BUSY;
                        mem_en   <= 1'b1;
                        wait_cnt <= '0;
                        owner_d  <= pick_d;
                        last_d   <= pick_d;
                        if_gnt   <= !pick_d;
                        d_gnt    <= pick_d;
                        if (pick_d) begin
                            mem_addr  <= d_addr;
                            mem_we    <= d_we;
                            mem_be    <= d_be;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_addr  <= if_addr;
                            mem_we    <= 1'b0;
                            mem_be    <= '1;
                            mem_wdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    // A ready arriving on the expiry edge still counts as success.
                    if (mem_ready || wait_cnt == CNT_LAST) begin
                        state  <= RESP;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        if (owner_d) begin
                            d_rdata <= resp_data;
                            d_done  <= mem_ready;
                            d_err   <= !mem_ready;
                        end else begin
                            if_rdata <= resp_data;
                            if_done  <= mem_ready;
                            if_err   <= !mem_ready;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    if_gnt <= 1'b0;
                    d_gnt  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, tie alternation, store, timeout, expiry-edge ready, reset mid-BUSY.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt;
    logic [31:0] if_rdata;
    logic        if_done, if_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt;
    logic [31:0] d_rdata;
    logic        d_done, d_err;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata),
        .if_done(if_done), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 64'({if_gnt, d_gnt, if_done, if_err, d_done, d_err, mem_en, mem_we}), 64'd0);
        chk({tag, "_be"}, 64'(mem_be), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_if_rdata"}, 64'(if_rdata), 64'd0);
        chk({tag, "_d_rdata"}, 64'(d_rdata), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Mutual exclusion of grants and of done/err, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n)
            chk("exclusive", 64'({if_gnt & d_gnt, if_done & if_err, d_done & d_err}), 64'd0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        do_reset();
        chk_all_zero("rst");

        // 1. Single fetch, memory ready in the first BUSY cycle
        if_req = 1'b1; if_addr = 32'h100;
        mem_ready = 1'b1; mem_rdata = 32'h00500093;
        tick();
        chk("t1_busy", 64'({mem_en, mem_we, mem_be, if_gnt, d_gnt, if_done}), 64'b1_0_1111_1_0_0);
        chk("t1_addr", 64'(mem_addr), 64'h100);
        tick();
        chk("t1_resp", 64'({mem_en, if_gnt, if_done, if_err}), 64'b0110);
        chk("t1_rdata", 64'(if_rdata), 64'h00500093);
        if_req = 1'b0;
        tick();
        chk("t1_idle", 64'({if_gnt, if_done, mem_en}), 64'd0);

        // 2. Tie after reset: data wins, then fetch wins the repeated tie
        do_reset();
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        mem_ready = 1'b1; mem_rdata = 32'h11111111;
        tick();
        chk("t2_gnt1", 64'({if_gnt, d_gnt, mem_en}), 64'b011);
        chk("t2_addr1", 64'(mem_addr), 64'h40);
        tick();
        chk("t2_ddone", 64'({d_done, if_done, d_rdata}), {2'b10, 32'h11111111});
        d_req = 1'b0;
        mem_rdata = 32'h22222222;
        tick();
        d_req = 1'b1;
        tick();
        chk("t2_gnt2", 64'({if_gnt, d_gnt, mem_en}), 64'b101);
        chk("t2_addr2", 64'(mem_addr), 64'h100);
        tick();
        chk("t2_ifdone", 64'({if_done, d_done}), 64'b10);
        chk("t2_if_rdata", 64'(if_rdata), 64'h22222222);
        chk("t2_d_rdata_hold", 64'(d_rdata), 64'h11111111);
        if_req = 1'b0;
        mem_rdata = 32'h33333333;
        tick();
        tick();
        chk("t2_gnt3", 64'({if_gnt, d_gnt}), 64'b01);
        tick();
        chk("t2_ddone2", 64'({d_done, d_rdata}), {1'b1, 32'h33333333});
        d_req = 1'b0;
        tick();

        // 3. Store with 4 wait cycles; mid-grant input changes must not leak
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h3; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF;
        mem_ready = 1'b0; mem_rdata = 32'hCAFEF00D;
        tick();
        d_addr = 32'hFFFF0000; d_wdata = 32'h0; d_be = 4'hC;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_ctl%0d", i), 64'({mem_en, mem_we, mem_be, d_gnt, d_done}), 64'b1_1_0011_1_0);
            chk($sformatf("t3_aw%0d", i), {mem_addr, mem_wdata}, {32'h2004, 32'hDEADBEEF});
            if (i == 4) mem_ready = 1'b1;
            tick();
        end
        chk("t3_done", 64'({d_done, d_err, mem_en}), 64'b100);
        chk("t3_rdata", 64'(d_rdata), 64'd0);
        d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        tick();

        // Give d_rdata a nonzero value so the timeout's clear is visible
        d_req = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h44444444;
        tick();
        tick();
        chk("t4_pre", 64'(d_rdata), 64'h44444444);
        d_req = 1'b0; mem_ready = 1'b0;
        tick();

        // 4. Timeout with MAX_WAIT = 15
        d_req = 1'b1;
        tick();
        n = 0;
        while (mem_en && n < 40) begin
            if (d_done || d_err) chk("t4_early", 64'({d_done, d_err}), 64'd0);
            n++;
            tick();
        end
        chk("t4_en_cycles", 64'(n), 64'd15);
        chk("t4_err", 64'({d_err, d_done, d_gnt}), 64'b101);
        chk("t4_rdata", 64'(d_rdata), 64'd0);
        d_req = 1'b0;
        tick();
        chk("t4_err_pulse", 64'({d_err, d_done}), 64'd0);
        if_req = 1'b1; if_addr = 32'h200; mem_ready = 1'b1; mem_rdata = 32'h55555555;
        tick();
        tick();
        chk("t4_next", 64'({if_done, if_err, if_rdata}), {2'b10, 32'h55555555});
        if_req = 1'b0; mem_ready = 1'b0;
        tick();

        // 5. mem_ready arrives exactly on the expiry edge
        d_req = 1'b1; mem_rdata = 32'h66666666;
        tick();
        for (int i = 0; i < 14; i++) tick();
        chk("t5_still_busy", 64'({mem_en, d_err, d_done}), 64'b100);
        mem_ready = 1'b1;
        tick();
        chk("t5_done", 64'({d_done, d_err}), 64'b10);
        chk("t5_rdata", 64'(d_rdata), 64'h66666666);
        d_req = 1'b0; mem_ready = 1'b0;
        tick();

        // 6. Reset asserted mid-BUSY
        if_req = 1'b1; if_addr = 32'h300;
        tick();
        tick();
        tick();
        chk("t6_busy", 64'({mem_en, if_gnt}), 64'b11);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("t6_rst");
        tick();
        chk("t6_no_pulse", 64'({if_done, if_err, d_done, d_err, if_gnt, mem_en}), 64'd0);
        rst_n = 1'b1;
        mem_ready = 1'b1; mem_rdata = 32'h77777777;
        tick();
        chk("t6_regrant", 64'({if_gnt, mem_en, mem_addr}), {2'b11, 32'h300});
        tick();
        chk("t6_done", 64'({if_done, if_rdata}), {1'b1, 32'h77777777});
        if_req = 1'b0; mem_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single-port unified instruction/data memory between two requesters: the instruction-fetch path (PC/IR-write phase of the multi-cycle control unit) and the load/store data path.
- Resolves contention round-robin and sequences one memory transaction at a time through a request/ready handshake.
- Returns read data and a one-cycle completion or timeout-error pulse to the winning requester.
- Sits between the control unit/datapath and the memory.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MAX_WAIT, 15, BUSY cycles without mem_ready before the transaction is aborted; legal range 1..255

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- if_req  in  1  fetch request; held until if_done or if_err is seen
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch side owns the memory port
- if_rdata  out  DATA_W  fetched word
- if_done  out  1  one-cycle completion pulse
- if_err  out  1  one-cycle timeout pulse
- d_req  in  1  data request; held until d_done or d_err is seen
- d_we  in  1  1 = store, 0 = load
- d_be  in  DATA_W/8  store byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt, d_rdata, d_done, d_err  out  1/DATA_W/1/1  same meaning as the fetch-side outputs, for the data side
- mem_en  out  1  memory transaction active
- mem_we  out  1  write strobe
- mem_be  out  DATA_W/8  byte enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid while mem_ready=1
- mem_ready  in  1  memory completes the current transaction

## Operation
FSM states are IDLE, BUSY and RESP. All outputs are registered.

- **IDLE**
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the side not granted last (last_gnt). last_gnt resets to "fetch", so the data side wins the first tie.
  - On a grant, latch the following and go to BUSY:
    - mem_addr from the winner's address.
    - mem_we: d_we for a data grant; 0 for a fetch.
    - mem_be: d_be for a data grant; all ones for a fetch.
    - mem_wdata: d_wdata for a data grant; 0 for a fetch.
  - Also update last_gnt and clear the wait counter.
- **BUSY**
  - mem_en=1. The winner's gnt=1.
  - Latched address, strobe, byte-enable and write-data values are stable for the whole state.
  - mem_ready=1 at an edge:
    - For a load/fetch, capture mem_rdata into the winner's rdata register.
    - For a store, load 0 into the winner's rdata register.
    - Go to RESP with done.
  - Otherwise the wait counter increments. On the edge where it would reach MAX_WAIT, go to RESP with err and rdata=0.
- **RESP**
  - mem_en=0. The winner's gnt stays 1.
  - Exactly one of the winner's done/err is 1, for this one cycle.
  - Both requests are ignored in RESP.
  - Next state is always IDLE.
- Requesters must deassert req at the edge ending RESP. The loser's req is held and is served from the following IDLE.
- The rdata registers of both sides hold their value until the next completion on that side.
- Changes to address, write data or byte enables while granted have no effect.
- Wait counter width is ceil(log2(MAX_WAIT+1)). It never wraps.

## Timing
- Reset (asynchronous, immediate, including mid-BUSY):
  - state = IDLE, last_gnt = fetch, counter = 0.
  - Every output is 0: gnts, dones, errs, rdatas, and all mem_* outputs.
  - An in-flight transaction is dropped; no done/err pulse is issued.
- Latency:
  - Request sampled at edge E0 → BUSY during E0..E1.
  - If mem_ready=1 in the first BUSY cycle, done is high during E1..E2.
  - Minimum: done 2 cycles after the sampling edge.
- Throughput: at most one access per 3 cycles (IDLE, BUSY, RESP).
- A mem_ready sampled on the same edge the counter expires counts as success. The err path is taken only when mem_ready=0 at that edge.
- Timeout: err is high during the cycle that starts MAX_WAIT cycles after BUSY is entered.
- done and err are never both high. Never more than one gnt is high.

## Test plan
1. **Single fetch:** if_req, if_addr=0x100, mem_ready=1 in the first BUSY cycle with mem_rdata=0x00500093.
   - Required: mem_en for 1 cycle with mem_addr=0x100, mem_be=0xF, mem_we=0.
   - Required: if_done pulses 2 cycles after the sampling edge and if_rdata=0x00500093.
2. **Simultaneous requests after reset:** if_req and d_req rise together.
   - Required: data is served first, then fetch, with d_done preceding if_done by 3 cycles.
   - Repeat the tie: fetch wins this time (alternation).
3. **Store:** d_we=1, d_be=0x3, d_addr=0x2004, d_wdata=0xDEADBEEF, memory ready after 4 wait cycles.
   - Required: mem_we=1 and mem_be=0x3, with all mem_* fields stable for 5 BUSY cycles.
   - Required: d_done then fires and d_rdata=0.
4. **Timeout:** MAX_WAIT=15, mem_ready held 0.
   - Required: mem_en is high for exactly 15 cycles, then a single d_err pulse, no d_done, and d_rdata=0.
   - The next request proceeds normally.
5. **Ready on expiry edge:** mem_ready=1 exactly on the edge where the counter expires.
   - Required: done, not err.
6. **Reset mid-BUSY:** assert rst_n=0 during BUSY.
   - Required: all outputs are 0 immediately, with no done/err pulse.
   - After release, a pending if_req completes normally.
